// File: rtl/counter_ctrl_unit_if.sv
// counter_ctrl_unit_if: button/tick/counter signals between the board, tick divider, counter and the control unit.
//   master: drives buttons, tick_in and count, and observes the control outputs (board/testbench side).
//   slave : the control unit; receives buttons, tick_in and count, and drives tick_out, clear, mode and running.
interface counter_ctrl_unit_if #(
  parameter int CW = 14
);
  logic          btn_run_stop;
  logic          btn_clear;
  logic          btn_mode;
  logic          tick_in;
  logic [CW-1:0] count;
  logic          tick_out;
  logic          clear;
  logic          mode;
  logic          running;
  modport master (
    output btn_run_stop, btn_clear, btn_mode, tick_in, count,
    input  tick_out, clear, mode, running
  );
  modport slave (
    input  btn_run_stop, btn_clear, btn_mode, tick_in, count,
    output tick_out, clear, mode, running
  );
endinterface

// File: rtl/counter_ctrl_unit.sv
// counter_ctrl_unit: button conditioning plus the STOP/RUN/CLEAR FSM that gates ticks and clears the 4-digit counter.
//   clk, reset (async, active high)
//   bus.btn_run_stop/btn_clear/btn_mode : raw buttons, asynchronous to clk
//   bus.tick_in : 10 Hz tick in; bus.count : counter value (read only for auto-stop)
//   bus.tick_out : gated tick; bus.clear : one-cycle clear; bus.mode : 0 up / 1 down; bus.running : FSM in RUN
//   Optional feature macro CTRL_AUTO_STOP_EN: stop at the terminal count instead of wrapping.
module counter_ctrl_unit #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int MAX_COUNT = 9999,
  parameter int CW = 14
) (
  input logic clk,
  input logic reset,
  counter_ctrl_unit_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, CLEAR = 2'd2} state_t;
  state_t state, state_nxt;
  logic [2:0] raw, s1, s2, stable, stable_d, pulse;
  logic run_p, clr_p, mode_p, mode_q, at_term, stop_term;
  assign raw = {bus.btn_mode, bus.btn_clear, bus.btn_run_stop};
  assign {mode_p, clr_p, run_p} = pulse;
  // The pulse is registered so a press costs 2 sync + DEBOUNCE_CYCLES + 1 edges.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      stable_d <= '0;
      pulse <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stable_d <= stable;
      pulse <= stable & ~stable_d;
    end
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic st;
    // Any sample agreeing with the accepted level restarts the count.
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        cnt <= '0;
        st <= 1'b0;
      end else if (s2[i] == st) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        st <= s2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    assign stable[i] = st;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= STOP;
      mode_q <= 1'b0;
    end else begin
      state <= state_nxt;
      mode_q <= mode_q ^ mode_p;
    end
  assign at_term = mode_q ? (bus.count == '0) : (bus.count == CW'(MAX_COUNT));
`ifdef CTRL_AUTO_STOP_EN
  assign stop_term = bus.tick_in & at_term;
`else
  logic unused_term;
  assign unused_term = at_term;
  assign stop_term = 1'b0;
`endif
  // Clear wins over run/stop; CLEAR and illegal encodings always fall back to STOP.
  always_comb begin
    state_nxt = STOP;
    case (state)
      STOP: state_nxt = clr_p ? CLEAR : run_p ? RUN : STOP;
      RUN: state_nxt = clr_p ? CLEAR : (run_p | stop_term) ? STOP : RUN;
      default: state_nxt = STOP;
    endcase
  end
  assign bus.running = (state == RUN);
  assign bus.clear = (state == CLEAR);
  assign bus.mode = mode_q;
  assign bus.tick_out = bus.tick_in & (state == RUN) & ~stop_term;
endmodule

// File: tb/tb_counter_ctrl_unit.sv
// tb_counter_ctrl_unit: directed scoreboard bench for counter_ctrl_unit with DEBOUNCE_CYCLES=4.
module tb_counter_ctrl_unit;
`ifdef CTRL_AUTO_STOP_EN
  localparam bit AS = 1'b1;
`else
  localparam bit AS = 1'b0;
`endif
  typedef struct {
    int c;
    logic [3:0] v;
    string n;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t e;
  logic [3:0] got;
  counter_ctrl_unit_if #(.CW(14)) bus ();
  counter_ctrl_unit #(.DEBOUNCE_CYCLES(4), .MAX_COUNT(9999), .CW(14)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign got = {bus.running, bus.mode, bus.clear, bus.tick_out};
  always @(negedge clk)
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      tests++;
      if (e.c != cyc || got !== e.v) begin
        fails++;
        $display("FAIL %s cyc=%0d got {run,mode,clr,tick}=%b expected=%b (due cyc %0d)", e.n, cyc, got, e.v, e.c);
      end
    end
  function automatic void chk(string n, bit r, bit m, bit c, bit t);
    exp_t x;
    x.c = cyc;
    x.v = {r, m, c, t};
    x.n = n;
    q.push_back(x);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(string n, int k, bit r, bit m);
    bus.tick_in = 1'b0;
    for (int i = 0; i < k; i++) begin
      chk(n, r, m, 0, 0);
      step();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    bus.btn_run_stop = 0;
    bus.btn_clear = 0;
    bus.btn_mode = 0;
    bus.tick_in = 1;
    bus.count = '0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_hold", 0, 0, 0, 0);
      step();
    end
    reset = 1'b0;
    bus.tick_in = 0;
    idle("rst_rel", 2, 0, 0);
    // run press: pulse 7 edges after first sample, RUN visible on the 8th
    bus.btn_run_stop = 1;
    for (int i = 0; i < 10; i++) begin
      bus.tick_in = (i >= 6);
      chk("s1_run", i >= 8, 0, 0, bus.tick_in && i >= 8);
      step();
    end
    bus.btn_run_stop = 0;
    for (int i = 0; i < 10; i++) begin
      bus.tick_in = i[0];
      chk("s1_hold", 1, 0, 0, bus.tick_in);
      step();
    end
    // 3-cycle clear glitch is rejected
    bus.tick_in = 0;
    bus.btn_clear = 1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) bus.btn_clear = 0;
      chk("s2_glitch", 1, 0, 0, 0);
      step();
    end
    // real clear: tick still passed on the cycle leaving RUN
    bus.btn_clear = 1;
    bus.tick_in = 1;
    for (int i = 0; i < 12; i++) begin
      chk("s2_clear", i < 8, 0, i == 8, i < 8);
      step();
    end
    bus.btn_clear = 0;
    for (int i = 0; i < 10; i++) begin
      bus.tick_in = !i[0];
      chk("s2_stop_ticks", 0, 0, 0, 0);
      step();
    end
    // simultaneous run and clear from STOP: clear wins
    bus.tick_in = 0;
    bus.btn_run_stop = 1;
    bus.btn_clear = 1;
    for (int i = 0; i < 12; i++) begin
      chk("s3_both", 0, 0, i == 8, 0);
      step();
    end
    bus.btn_run_stop = 0;
    bus.btn_clear = 0;
    idle("s3_after", 8, 0, 0);
    // mode toggle in STOP
    bus.btn_mode = 1;
    for (int i = 0; i < 10; i++) begin
      chk("s4_mode_stop", 0, i >= 8, 0, 0);
      step();
    end
    bus.btn_mode = 0;
    idle("s4_mode_rel", 8, 0, 1);
    bus.btn_run_stop = 1;
    for (int i = 0; i < 10; i++) begin
      chk("s4_run", i >= 8, 1, 0, 0);
      step();
    end
    bus.btn_run_stop = 0;
    idle("s4_run_rel", 8, 1, 1);
    // mode toggle in RUN
    bus.btn_mode = 1;
    for (int i = 0; i < 10; i++) begin
      chk("s4_mode_run", 1, i < 8, 0, 0);
      step();
    end
    bus.btn_mode = 0;
    idle("s4_mode_run_rel", 8, 1, 0);
    // terminal count in up mode
    bus.count = 14'd9998;
    bus.tick_in = 1;
    chk("s5_nonterm", 1, 0, 0, 1);
    step();
    bus.count = 14'd9999;
    chk("s5_term_tick", 1, 0, 0, !AS);
    step();
    bus.tick_in = 0;
    chk("s5_term_state", !AS, 0, 0, 0);
    step();
    bus.count = 14'd5;
    idle("s5_after", 3, !AS, 0);
    // mode pulse lands during the CLEAR cycle
    bus.btn_clear = 1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) bus.btn_mode = 1;
      chk("s4_clr_mode", i < 8 ? !AS : 1'b0, i >= 9, i == 8, 0);
      step();
    end
    bus.btn_clear = 0;
    bus.btn_mode = 0;
    idle("s4_clr_after", 8, 0, 1);
    bus.btn_run_stop = 1;
    for (int i = 0; i < 10; i++) begin
      chk("s6_run", i >= 8, 1, 0, 0);
      step();
    end
    bus.btn_run_stop = 0;
    idle("s6_run_rel", 8, 1, 1);
    // async reset mid-debounce of a mode press
    bus.btn_mode = 1;
    for (int i = 0; i < 3; i++) begin
      chk("s6_deb", 1, 1, 0, 0);
      step();
    end
    reset = 1'b1;
    bus.btn_mode = 0;
    bus.tick_in = 1;
    chk("s6_async", 0, 0, 0, 0);
    step();
    chk("s6_rst_hold", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    idle("s6_after", 12, 0, 0);
    // button held through reset release
    reset = 1'b1;
    bus.btn_run_stop = 1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("s7_held", i >= 8, 0, 0, 0);
      step();
    end
    bus.btn_run_stop = 0;
    step();
    step();
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
      fails += q.size();
      tests += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
